alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_if.sv | 39 +++
 rtl/alu_issue_stage.sv | 157 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Fetch, register-file read, execute and writeback signals of the ALU issue stage.
// slave is the issue stage's view of the bundle; master is the surrounding pipeline's view.
interface alu_issue_stage_if;
  logic        if_valid;
  logic [0:31] if_instr;
  logic        if_ready;

  logic [0:4]  rf_addr_a;
  logic [0:4]  rf_addr_b;
  logic [0:63] rf_data_a;
  logic [0:63] rf_data_b;

  logic        ex_valid;
  logic        ex_ready;
  logic [0:5]  ex_op_code;
  logic [0:5]  ex_r_ins;
  logic [0:1]  ex_ww;
  logic [0:63] ex_rA_val;
  logic [0:63] ex_rB_val;
  logic [0:4]  ex_rd;

  logic        wb_valid;
  logic [0:4]  wb_rd;

  logic [0:15] stall_cnt;
  logic [0:7]  illegal_cnt;

  modport slave (
    input  if_valid, if_instr, rf_data_a, rf_data_b, ex_ready, wb_valid, wb_rd,
    output if_ready, rf_addr_a, rf_addr_b, ex_valid, ex_op_code, ex_r_ins, ex_ww,
           ex_rA_val, ex_rB_val, ex_rd, stall_cnt, illegal_cnt
  );

  modport master (
    output if_valid, if_instr, rf_data_a, rf_data_b, ex_ready, wb_valid, wb_rd,
    input  if_ready, rf_addr_a, rf_addr_b, ex_valid, ex_op_code, ex_r_ins, ex_ww,
           ex_rA_val, ex_rB_val, ex_rd, stall_cnt, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, scoreboard hazard check, one-entry execute skid; 1-cycle fetch-to-ex latency.
// Fetch is backpressured on a pending source register or when the held entry is not drained by ex_ready.
module alu_issue_stage (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [5:0] OP_R_ALU     = 6'b101010;
  localparam logic [5:0] OP_LOAD      = 6'b100000;
  localparam logic [5:0] OP_STORE     = 6'b100001;
  localparam logic [5:0] OP_BRANCH_EZ = 6'b100010;
  localparam logic [5:0] OP_BRANCH_NZ = 6'b100011;
  localparam logic [5:0] OP_NOP       = 6'b111100;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [0:5]  ex_op_q, ex_op_d;
  logic [0:5]  ex_rins_q, ex_rins_d;
  logic [0:1]  ex_ww_q, ex_ww_d;
  logic [0:63] ex_a_q, ex_a_d;
  logic [0:63] ex_b_q, ex_b_d;
  logic [0:4]  ex_rd_q, ex_rd_d;
  logic [0:15] stall_q, stall_d;
  logic [0:7]  ill_q, ill_d;

  logic [0:5] op;
  logic [0:4] rd, ra, rb;
  logic [0:1] ww;
  logic [0:5] rins;
  logic       unused_bits;

  assign op          = bus.if_instr[0:5];
  assign rd          = bus.if_instr[6:10];
  assign ra          = bus.if_instr[11:15];
  assign rb          = bus.if_instr[16:20];
  assign ww          = bus.if_instr[24:25];
  assign rins        = bus.if_instr[26:31];
  assign unused_bits = ^bus.if_instr[21:23];

  logic is_ralu, is_load, is_store, is_br, is_nop, is_fwd, is_ill;

  assign is_ralu  = (op == OP_R_ALU);
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_br    = (op == OP_BRANCH_EZ) || (op == OP_BRANCH_NZ);
  assign is_nop   = (op == OP_NOP);
  assign is_fwd   = is_ralu || is_load || is_store || is_br;
  assign is_ill   = !(is_fwd || is_nop);

  logic [31:0] src;
  logic        hazard, fire, fwd_fire;

  always_comb begin
    src           = '0;
    bus.rf_addr_a = '0;
    bus.rf_addr_b = '0;
    if (is_ralu) begin
      src[ra] = 1'b1;
      src[rb] = 1'b1;
      src[rd] = 1'b1;
      bus.rf_addr_a = ra;
      bus.rf_addr_b = rb;
    end else if (is_load) begin
      src[ra] = 1'b1;
      src[rd] = 1'b1;
      bus.rf_addr_a = ra;
    end else if (is_store) begin
      src[ra] = 1'b1;
      src[rd] = 1'b1;
      bus.rf_addr_b = rd;
    end else if (is_br) begin
      src[rd] = 1'b1;
      bus.rf_addr_a = rd;
    end
  end

  // Hazard looks only at the registered scoreboard, so a writeback clears it one cycle later.
  assign hazard       = |(src & pend_q);
  assign bus.if_ready = !reset && !hazard && (state_q == EMPTY || bus.ex_ready);
  assign fire         = bus.if_valid && bus.if_ready;
  assign fwd_fire     = fire && is_fwd;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ex_op_d   = ex_op_q;
    ex_rins_d = ex_rins_q;
    ex_ww_d   = ex_ww_q;
    ex_a_d    = ex_a_q;
    ex_b_d    = ex_b_q;
    ex_rd_d   = ex_rd_q;
    stall_d   = stall_q;
    ill_d     = ill_q;

    case (state_q)
      EMPTY:   if (fwd_fire) state_d = FULL;
      FULL:    if (bus.ex_ready && !fwd_fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (fwd_fire) begin
      ex_op_d   = op;
      ex_rins_d = rins;
      ex_ww_d   = ww;
      ex_a_d    = bus.rf_data_a;
      ex_b_d    = bus.rf_data_b;
      ex_rd_d   = rd;
    end

    // Clear first, then set, so a same-register set and retire leaves the bit pending.
    if (bus.wb_valid) pend_d[bus.wb_rd] = 1'b0;
    if (fire && (is_ralu || is_load)) pend_d[rd] = 1'b1;

    if (bus.if_valid && hazard && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    if (fire && is_ill && ill_q != 8'hFF) ill_d = ill_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      pend_q    <= '0;
      ex_op_q   <= '0;
      ex_rins_q <= '0;
      ex_ww_q   <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
      ex_rd_q   <= '0;
      stall_q   <= '0;
      ill_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ex_op_q   <= ex_op_d;
      ex_rins_q <= ex_rins_d;
      ex_ww_q   <= ex_ww_d;
      ex_a_q    <= ex_a_d;
      ex_b_q    <= ex_b_d;
      ex_rd_q   <= ex_rd_d;
      stall_q   <= stall_d;
      ill_q     <= ill_d;
    end
  end

  assign bus.ex_valid    = (state_q == FULL);
  assign bus.ex_op_code  = ex_op_q;
  assign bus.ex_r_ins    = ex_rins_q;
  assign bus.ex_ww       = ex_ww_q;
  assign bus.ex_rA_val   = ex_a_q;
  assign bus.ex_rB_val   = ex_b_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.illegal_cnt = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then random traffic against a queue-based issue model.
module tb_alu_issue_stage;

  localparam logic [5:0] OP_R_ALU     = 6'b101010;
  localparam logic [5:0] OP_LOAD      = 6'b100000;
  localparam logic [5:0] OP_STORE     = 6'b100001;
  localparam logic [5:0] OP_BRANCH_EZ = 6'b100010;
  localparam logic [5:0] OP_BRANCH_NZ = 6'b100011;
  localparam logic [5:0] OP_NOP       = 6'b111100;

  logic clk;
  logic reset;
  alu_issue_stage_if bus ();

  alu_issue_stage dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:63] regfile [32];
  assign bus.rf_data_a = regfile[bus.rf_addr_a];
  assign bus.rf_data_b = regfile[bus.rf_addr_b];

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the execute side and the scoreboard should look like.
  bit          m_full;
  bit          m_pend [32];
  logic [5:0]  m_op, m_rins;
  logic [1:0]  m_ww;
  logic [63:0] m_a, m_b;
  logic [4:0]  m_rd;
  int          m_stall, m_ill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:31] mk(logic [5:0] op, int rd, int ra, int rb,
                                     logic [1:0] ww, logic [5:0] rins);
    return {op, 5'(rd), 5'(ra), 5'(rb), 3'b000, ww, rins};
  endfunction

  function automatic bit is_fwd(logic [5:0] op);
    return op == OP_R_ALU || op == OP_LOAD || op == OP_STORE ||
           op == OP_BRANCH_EZ || op == OP_BRANCH_NZ;
  endfunction

  function automatic bit is_illegal(logic [5:0] op);
    return !is_fwd(op) && op != OP_NOP;
  endfunction

  function automatic logic [4:0] exp_addr_a(logic [0:31] ins);
    logic [5:0] op = ins[0:5];
    if (op == OP_R_ALU || op == OP_LOAD) return ins[11:15];
    if (op == OP_BRANCH_EZ || op == OP_BRANCH_NZ) return ins[6:10];
    return 5'd0;
  endfunction

  function automatic logic [4:0] exp_addr_b(logic [0:31] ins);
    logic [5:0] op = ins[0:5];
    if (op == OP_R_ALU) return ins[16:20];
    if (op == OP_STORE) return ins[6:10];
    return 5'd0;
  endfunction

  function automatic bit m_hazard(logic [0:31] ins);
    int q[$];
    logic [5:0] op = ins[0:5];
    if (op == OP_R_ALU) begin
      q.push_back(int'(ins[11:15])); q.push_back(int'(ins[16:20])); q.push_back(int'(ins[6:10]));
    end else if (op == OP_LOAD || op == OP_STORE) begin
      q.push_back(int'(ins[11:15])); q.push_back(int'(ins[6:10]));
    end else if (op == OP_BRANCH_EZ || op == OP_BRANCH_NZ) begin
      q.push_back(int'(ins[6:10]));
    end
    foreach (q[i]) if (m_pend[q[i]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_full = 0; m_op = '0; m_rins = '0; m_ww = '0; m_a = '0; m_b = '0; m_rd = '0;
    m_stall = 0; m_ill = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  task automatic setin(input bit v, input logic [0:31] ins, input bit er,
                       input bit wv, input int wr);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.ex_ready = er;
    bus.wb_valid = wv;
    bus.wb_rd    = 5'(wr);
  endtask

  // One clock: check combinational outputs, step the model on the edge, check registered outputs.
  task automatic cycle();
    logic [0:31] ins;
    logic [5:0]  op;
    bit          hz, rdy, fire;
    #1;
    ins = bus.if_instr;
    op  = ins[0:5];
    hz  = m_hazard(ins);
    rdy = !hz && (!m_full || bus.ex_ready);
    chk("if_ready", 64'(bus.if_ready), 64'(rdy));
    chk("rf_addr_a", 64'(bus.rf_addr_a), 64'(exp_addr_a(ins)));
    chk("rf_addr_b", 64'(bus.rf_addr_b), 64'(exp_addr_b(ins)));
    fire = bus.if_valid && rdy;
    @(posedge clk);
    if (bus.if_valid && hz && m_stall < 65535) m_stall++;
    if (fire && is_illegal(op) && m_ill < 255) m_ill++;
    if (fire && is_fwd(op)) begin
      m_op = op; m_rins = ins[26:31]; m_ww = ins[24:25]; m_rd = ins[6:10];
      m_a = regfile[exp_addr_a(ins)]; m_b = regfile[exp_addr_b(ins)];
      m_full = 1;
    end else if (bus.ex_ready) begin
      m_full = 0;
    end
    if (bus.wb_valid) m_pend[bus.wb_rd] = 0;
    if (fire && (op == OP_R_ALU || op == OP_LOAD)) m_pend[ins[6:10]] = 1;
    @(negedge clk);
    chk("ex_valid", 64'(bus.ex_valid), 64'(m_full));
    chk("ex_op_code", 64'(bus.ex_op_code), 64'(m_op));
    chk("ex_r_ins", 64'(bus.ex_r_ins), 64'(m_rins));
    chk("ex_ww", 64'(bus.ex_ww), 64'(m_ww));
    chk("ex_rA_val", bus.ex_rA_val, m_a);
    chk("ex_rB_val", bus.ex_rB_val, m_b);
    chk("ex_rd", 64'(bus.ex_rd), 64'(m_rd));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    chk("illegal_cnt", 64'(bus.illegal_cnt), 64'(m_ill));
  endtask

  task automatic drive(input bit v, input logic [0:31] ins, input bit er,
                       input bit wv, input int wr);
    setin(v, ins, er, wv, wr);
    cycle();
  endtask

  function automatic logic [0:31] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = OP_R_ALU;
      1: op = OP_LOAD;
      2: op = OP_STORE;
      3: op = OP_BRANCH_EZ;
      4: op = OP_BRANCH_NZ;
      5: op = OP_NOP;
      default: op = 6'($urandom_range(0, 63));
    endcase
    return mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
  endfunction

  initial begin
    logic [0:31] held;
    logic [5:0]  bad;

    foreach (regfile[i]) regfile[i] = {$urandom, $urandom};
    regfile[1] = 64'h0001_0002_0003_0004;
    reset = 1'b1;
    setin(0, '0, 0, 0, 0);
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_ex_rA_val", bus.ex_rA_val, 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    reset = 1'b0;

    // Vector-add issue with one-cycle latency.
    drive(1, mk(OP_R_ALU, 3, 1, 2, 2'b01, 6'b000110), 1, 0, 0);
    chk("vadd_ex_valid", 64'(bus.ex_valid), 64'd1);
    chk("vadd_op", 64'(bus.ex_op_code), 64'(6'b101010));
    chk("vadd_rins", 64'(bus.ex_r_ins), 64'(6'b000110));
    chk("vadd_ww", 64'(bus.ex_ww), 64'(2'b01));
    chk("vadd_rA_val", bus.ex_rA_val, 64'h0001_0002_0003_0004);
    chk("vadd_rd", 64'(bus.ex_rd), 64'd3);
    setin(0, mk(OP_R_ALU, 9, 3, 4, 0, 0), 1, 0, 0);
    #1 chk("pend3_blocks", 64'(bus.if_ready), 64'd0);
    cycle();

    // RAW on r3: stalls until the writeback becomes visible.
    held = mk(OP_R_ALU, 6, 3, 4, 0, 0);
    repeat (3) drive(1, held, 1, 0, 0);
    chk("stall_3", 64'(bus.stall_cnt), 64'd3);
    drive(1, held, 1, 1, 3);
    chk("stall_4", 64'(bus.stall_cnt), 64'd4);
    setin(1, held, 1, 0, 0);
    #1 chk("wb_unblocks", 64'(bus.if_ready), 64'd1);
    cycle();

    // Execute backpressure holds the payload, then releases with no bubble.
    drive(1, mk(OP_R_ALU, 7, 8, 9, 2'b10, 6'b000001), 1, 0, 0);
    chk("bp_first_rd", 64'(bus.ex_rd), 64'd7);
    for (int i = 0; i < 4; i++) begin
      setin(1, mk(OP_R_ALU, 10, 11, 12, 0, 6'b000010), 0, 0, 0);
      #1 chk("bp_if_ready", 64'(bus.if_ready), 64'd0);
      cycle();
      chk("bp_hold_rd", 64'(bus.ex_rd), 64'd7);
      chk("bp_hold_a", bus.ex_rA_val, regfile[8]);
      chk("bp_hold_valid", 64'(bus.ex_valid), 64'd1);
    end
    drive(1, mk(OP_R_ALU, 10, 11, 12, 0, 6'b000010), 1, 0, 0);
    chk("bp_next_rd", 64'(bus.ex_rd), 64'd10);
    chk("bp_next_valid", 64'(bus.ex_valid), 64'd1);

    // Illegal and NOP are consumed without reaching execute.
    drive(1, mk(6'b000000, 1, 2, 3, 0, 0), 1, 0, 0);
    drive(1, mk(OP_NOP, 4, 5, 6, 0, 0), 1, 0, 0);
    chk("nop_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("illegal_1", 64'(bus.illegal_cnt), 64'd1);
    for (int i = 0; i < 300; i++) begin
      bad = 6'($urandom_range(0, 63));
      if (!is_illegal(bad)) bad = 6'b000000;
      drive(1, mk(bad, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0),
            1'($urandom_range(0, 1)), 0, 0);
    end
    chk("illegal_sat", 64'(bus.illegal_cnt), 64'd255);

    // Set and retire of the same register in one cycle: set wins.
    drive(1, mk(OP_LOAD, 5, 1, 0, 0, 0), 1, 1, 5);
    setin(0, mk(OP_R_ALU, 13, 5, 1, 0, 0), 1, 0, 0);
    #1 chk("set_wins", 64'(bus.if_ready), 64'd0);
    cycle();

    // Reset while holding an un-accepted entry.
    drive(1, mk(OP_BRANCH_EZ, 2, 0, 0, 0, 0), 1, 0, 0);
    setin(0, '0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("mid_rst_if_ready", 64'(bus.if_ready), 64'd0);
    chk("mid_rst_op", 64'(bus.ex_op_code), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall_cnt), 64'd0);
    chk("mid_rst_illegal", 64'(bus.illegal_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1, mk(OP_R_ALU, 11, 5, 6, 0, 0), 1, 0, 0);
    chk("post_rst_fire", 64'(bus.ex_valid), 64'd1);
    chk("post_rst_rd", 64'(bus.ex_rd), 64'd11);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) < 7), $urandom_range(0, 31));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
